// File: rtl/posit_mult_seq.sv
// Multi-cycle posit<N,ES> multiplier (IDLE -> DEC -> MUL -> ENC -> DONE) with valid/ready on both sides.
// Optional feature: define POSIT_MULT_INEXACT_EN to add the registered 'inexact' output.
module posit_mult_seq #(
    parameter int N  = 32,
    parameter int ES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] product,
    output logic         nar,
    output logic         zero
`ifdef POSIT_MULT_INEXACT_EN
    ,
    output logic         inexact
`endif
);

    localparam int MW = N - ES - 1;     // significand width including the hidden bit
    localparam int FW = MW - 1;
    localparam int PW = 2 * MW;
    localparam int EW = ES + 1;
    localparam int KW = $clog2(N) + 2;
    localparam int SW = $clog2(N) + ES + 3;
    localparam int TW = ES + PW - 1;    // exponent field followed by product fraction
    localparam int FL = N + TW;         // longest legal regime still leaves the whole tail in view
    localparam logic signed [SW-1:0] K_MAX  = SW'(N - 2);
    localparam logic [SW-1:0]        E_MASK = SW'((1 << ES) - 1);
    localparam logic [N-1:0]         NAR_W  = {1'b1, {(N-1){1'b0}}};
    localparam logic [FL-1:0]        TOP_ONE = {1'b1, {(FL-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_DEC, S_MUL, S_ENC, S_DONE} state_t;

    typedef struct packed {
        logic [KW-1:0] k;
        logic [EW-1:0] e;
        logic [MW-1:0] sig;
    } dec_t;

    function automatic dec_t decode(input logic [N-2:0] m);
        logic [N-1:0] body;
        logic [N-1:0] rest;
        logic         run_bit;
        logic         stop;
        int           run;
        dec_t         d;
        body    = {m, 1'b0};
        run_bit = body[N-1];
        run     = 0;
        stop    = 1'b0;
        for (int i = N - 1; i >= 1; i--) begin
            if (!stop && (body[i] == run_bit)) begin
                run = run + 1;
            end else begin
                stop = 1'b1;
            end
        end
        // Shifting by N (run to word end) leaves zeros, so missing exponent bits read as 0.
        rest  = body << (run + 1);
        d.k   = run_bit ? KW'(run - 1) : KW'(-run);
        d.e   = EW'(rest >> (N - ES));
        d.sig = {1'b1, FW'(rest >> (N - ES - FW))};
        return d;
    endfunction

    state_t state_q, state_d;

    logic [N-1:0]           a_q, a_d, b_q, b_d;
    logic [KW-1:0]          ka_q, ka_d, kb_q, kb_d;
    logic [EW-1:0]          ea_q, ea_d, eb_q, eb_d;
    logic [MW-1:0]          siga_q, siga_d, sigb_q, sigb_d;
    logic                   sign_q, sign_d, snar_q, snar_d, szero_q, szero_d;
    logic signed [SW-1:0]   scale_q, scale_d;
    logic [PW-2:0]          frac_q, frac_d;
    logic [N-1:0]           product_q, product_d;
    logic                   nar_q, nar_d, zero_q, zero_d;
`ifdef POSIT_MULT_INEXACT_EN
    logic                   inexact_q, inexact_d;
    logic                   enc_inexact;
`endif

    logic [N-2:0]           mag_a, mag_b;
    dec_t                   dec_a, dec_b;
    logic [PW-1:0]          prod;
    logic signed [SW-1:0]   ksum;
    logic signed [SW-1:0]   k_s;
    logic [SW-1:0]          e_u, rl;
    logic [TW-1:0]          tail;
    logic [FL-1:0]          reg_vec, tail_vec, f;
    logic [N-2:0]           mag_t, mag_r, mag_f;
    logic                   guard, sticky, sat;
    logic [N-1:0]           res, enc_p;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; operands are only taken in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = in_valid ? S_DEC : S_IDLE;
            S_DEC:   state_d = S_MUL;
            S_MUL:   state_d = S_ENC;
            S_ENC:   state_d = S_DONE;
            S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand decode, significand product and normalisation.
    always_comb begin
        mag_a = (N-1)'(a_q[N-1] ? (~a_q + N'(1'b1)) : a_q);
        mag_b = (N-1)'(b_q[N-1] ? (~b_q + N'(1'b1)) : b_q);
        dec_a = decode(mag_a);
        dec_b = decode(mag_b);
        prod  = PW'(siga_q) * PW'(sigb_q);
        ksum  = SW'($signed(ka_q)) + SW'($signed(kb_q));
    end

    // Re-encode: regime, exponent, fraction, then round-to-nearest-even with saturation.
    always_comb begin
        k_s  = scale_q >>> ES;
        e_u  = SW'(scale_q) & E_MASK;
        tail = (TW'(e_u) << (PW - 1)) | TW'(frac_q);
        if (!k_s[SW-1]) begin
            reg_vec = ~({FL{1'b1}} >> (SW'(k_s) + SW'(1'b1)));
            rl      = SW'(k_s) + SW'(2'd2);
        end else begin
            reg_vec = TOP_ONE >> SW'(-k_s);
            rl      = SW'(-k_s) + SW'(1'b1);
        end
        tail_vec = {tail, {N{1'b0}}} >> rl;
        f        = reg_vec | tail_vec;
        mag_t    = f[FL-1 -: N-1];
        guard    = f[FL-N];
        sticky   = |f[FL-N-1:0];
        mag_r    = mag_t + (N-1)'(guard & (sticky | mag_t[0]));
        if (k_s > K_MAX) begin
            mag_f = {(N-1){1'b1}};
            sat   = 1'b1;
        end else if (k_s < -K_MAX) begin
            mag_f = (N-1)'(1'b1);
            sat   = 1'b1;
        end else begin
            mag_f = mag_r;
            sat   = 1'b0;
        end
        res   = {1'b0, mag_f};
        enc_p = sign_q ? (~res + N'(1'b1)) : res;
`ifdef POSIT_MULT_INEXACT_EN
        enc_inexact = sat | guard | sticky;
`endif
    end

    // Datapath next values per state; everything else holds.
    always_comb begin
        a_d = a_q;   b_d = b_q;
        ka_d = ka_q; kb_d = kb_q; ea_d = ea_q; eb_d = eb_q;
        siga_d = siga_q; sigb_d = sigb_q;
        sign_d = sign_q; snar_d = snar_q; szero_d = szero_q;
        scale_d = scale_q; frac_d = frac_q;
        product_d = product_q; nar_d = nar_q; zero_d = zero_q;
`ifdef POSIT_MULT_INEXACT_EN
        inexact_d = inexact_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                end else begin
                    a_d = a_q;
                    b_d = b_q;
                end
            end
            S_DEC: begin
                sign_d  = a_q[N-1] ^ b_q[N-1];
                snar_d  = (a_q == NAR_W) || (b_q == NAR_W);
                szero_d = (a_q == N'(1'b0)) || (b_q == N'(1'b0));
                ka_d = dec_a.k;     kb_d = dec_b.k;
                ea_d = dec_a.e;     eb_d = dec_b.e;
                siga_d = dec_a.sig; sigb_d = dec_b.sig;
            end
            S_MUL: begin
                scale_d = (ksum <<< ES) + $signed(SW'(ea_q)) + $signed(SW'(eb_q))
                        + $signed(SW'(prod[PW-1]));
                frac_d  = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
            end
            S_ENC: begin
                if (snar_q) begin
                    product_d = NAR_W;
                    nar_d     = 1'b1;
                    zero_d    = 1'b0;
                end else if (szero_q) begin
                    product_d = N'(1'b0);
                    nar_d     = 1'b0;
                    zero_d    = 1'b1;
                end else begin
                    product_d = enc_p;
                    nar_d     = 1'b0;
                    zero_d    = 1'b0;
                end
`ifdef POSIT_MULT_INEXACT_EN
                inexact_d = (snar_q || szero_q) ? 1'b0 : enc_inexact;
`endif
            end
            default: begin
                product_d = product_q;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;      b_q <= '0;
            ka_q <= '0;     kb_q <= '0;   ea_q <= '0;   eb_q <= '0;
            siga_q <= '0;   sigb_q <= '0;
            sign_q <= 1'b0; snar_q <= 1'b0; szero_q <= 1'b0;
            scale_q <= '0;  frac_q <= '0;
            product_q <= '0; nar_q <= 1'b0; zero_q <= 1'b0;
`ifdef POSIT_MULT_INEXACT_EN
            inexact_q <= 1'b0;
`endif
        end else begin
            a_q <= a_d;       b_q <= b_d;
            ka_q <= ka_d;     kb_q <= kb_d;   ea_q <= ea_d;   eb_q <= eb_d;
            siga_q <= siga_d; sigb_q <= sigb_d;
            sign_q <= sign_d; snar_q <= snar_d; szero_q <= szero_d;
            scale_q <= scale_d; frac_q <= frac_d;
            product_q <= product_d; nar_q <= nar_d; zero_q <= zero_d;
`ifdef POSIT_MULT_INEXACT_EN
            inexact_q <= inexact_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;
    assign nar       = nar_q;
    assign zero      = zero_q;
`ifdef POSIT_MULT_INEXACT_EN
    assign inexact   = inexact_q;
`endif

endmodule
